// File: rtl/er_exec_ctrl.sv
// rtl/er_exec_ctrl.sv - executable-region attestation controller
// Tracks atomic entry-to-exit execution of a configured code region and requests CPU reset on violation.
module er_exec_ctrl #(
   parameter logic [15:0] RESET_HANDLER = 16'h0000,
   parameter logic [15:0] CFG_BASE      = 16'h0140
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc,
   input  logic        irq,
   input  logic [15:0] data_addr,
   input  logic        data_wr,
   input  logic [15:0] data_wdata,
   input  logic [15:0] dma_addr,
   input  logic        dma_en,
   output logic [15:0] er_min,
   output logic [15:0] er_max,
   output logic        exec,
   output logic        reset,
   output logic [7:0]  abort_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_RUN, S_DONE, S_ABORT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] er_min_q, er_min_d;
   logic [15:0] er_max_q, er_max_d;
   logic        exec_q, exec_d;
   logic        reset_q, reset_d;
   logic [7:0]  abort_cnt_q, abort_cnt_d;

   logic hit_min, hit_max, hit_ctl, cfg_open, cfg_acc, arm_req;
   logic er_write, in_er, at_min, at_max;

   assign hit_min  = data_wr && (data_addr == CFG_BASE);
   assign hit_max  = data_wr && (data_addr == CFG_BASE + 16'd2);
   assign hit_ctl  = data_wr && (data_addr == CFG_BASE + 16'd4);
   assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);
   assign cfg_acc  = cfg_open && (hit_min || hit_max || hit_ctl);
   assign arm_req  = hit_ctl && data_wdata[0];

   assign er_write = (data_wr && (data_addr >= er_min_q) && (data_addr <= er_max_q)) ||
                     (dma_en  && (dma_addr  >= er_min_q) && (dma_addr  <= er_max_q));
   assign in_er    = (pc >= er_min_q) && (pc <= er_max_q);
   assign at_min   = (pc == er_min_q);
   assign at_max   = (pc == er_max_q);

   always_comb begin
      state_d     = state_q;
      er_min_d    = er_min_q;
      er_max_d    = er_max_q;
      abort_cnt_d = abort_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (arm_req && (er_min_q <= er_max_q)) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (er_write)    state_d = S_ABORT;
            else if (at_min) state_d = S_RUN;
            else if (in_er)  state_d = S_ABORT;
         end
         S_RUN: begin
            if (irq || er_write || dma_en || !in_er) state_d = S_ABORT;
            else if (at_max)                         state_d = S_DONE;
         end
         S_DONE: begin
            if (er_write || cfg_acc) state_d = S_IDLE;
            else if (at_min)         state_d = S_RUN;
         end
         S_ABORT: begin
            if (pc == RESET_HANDLER) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Register updates land in the same cycle as any DONE->IDLE they cause.
      if (cfg_acc && hit_min) er_min_d = data_wdata;
      if (cfg_acc && hit_max) er_max_d = data_wdata;

      if ((state_d == S_ABORT) && (state_q != S_ABORT) && (abort_cnt_q != 8'hFF))
         abort_cnt_d = abort_cnt_q + 8'd1;

      exec_d  = (state_d == S_DONE);
      reset_d = (state_d == S_ABORT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         er_min_q    <= 16'h0000;
         er_max_q    <= 16'h0000;
         exec_q      <= 1'b0;
         reset_q     <= 1'b0;
         abort_cnt_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         er_min_q    <= er_min_d;
         er_max_q    <= er_max_d;
         exec_q      <= exec_d;
         reset_q     <= reset_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign er_min    = er_min_q;
   assign er_max    = er_max_q;
   assign exec      = exec_q;
   assign reset     = reset_q;
   assign abort_cnt = abort_cnt_q;

endmodule

// File: doc/er_exec_ctrl.md
ER_EXEC_CTRL -- requirements
Module: er_exec_ctrl

Interface
REQ-001 SHALL have parameter RESET_HANDLER, default 16'h0000, the PC value that marks reset completion.
REQ-002 SHALL have parameter CFG_BASE, default 16'h0140, the word address of the first config register.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc  input  16  current CPU program counter.
REQ-006 SHALL have port irq  input  1  interrupt being taken this cycle.
REQ-007 SHALL have port data_addr  input  16  CPU data-bus address.
REQ-008 SHALL have port data_wr  input  1  CPU word write strobe, one write per cycle high.
REQ-009 SHALL have port data_wdata  input  16  CPU write data.
REQ-010 SHALL have port dma_addr  input  16  DMA address.
REQ-011 SHALL have port dma_en  input  1  DMA access strobe.
REQ-012 SHALL have port er_min  output  16  configured executable-region (ER) first address.
REQ-013 SHALL have port er_max  output  16  configured ER exit address.
REQ-014 SHALL have port exec  output  1  ER ran atomically entry-to-exit and is unmodified since.
REQ-015 SHALL have port reset  output  1  active-high CPU reset request.
REQ-016 SHALL have port abort_cnt  output  8  saturating count of ABORT entries.

Function
REQ-017 SHALL decode CPU writes: CFG_BASE -> er_min, CFG_BASE+2 -> er_max, CFG_BASE+4 -> control (bit0 = ARM, other bits ignored, not stored).
REQ-018 SHALL accept config writes only in IDLE or DONE; config writes in ARMED, RUN, ABORT SHALL be ignored (no register change, no state effect).
REQ-019 SHALL define er_write = (data_wr and er_min<=data_addr<=er_max) or (dma_en and er_min<=dma_addr<=er_max), comparisons unsigned, inclusive.
REQ-020 SHALL define in_er = er_min<=pc<=er_max, unsigned, inclusive.
REQ-021 SHALL implement states IDLE, ARMED, RUN, DONE, ABORT, one registered state, transitions one clock after the qualifying inputs.
REQ-022 IDLE: ARM write with er_min<=er_max -> ARMED; ARM write with er_min>er_max ignored, remain IDLE.
REQ-023 ARMED: er_write -> ABORT; else pc==er_min -> RUN; else in_er (entry not at er_min) -> ABORT; else stay.
REQ-024 RUN, priority high to low: irq, er_write, any dma_en, or pc outside ER -> ABORT; pc==er_max -> DONE; else stay.
REQ-025 DONE: er_write or accepted config write -> IDLE; else pc==er_min -> RUN; else stay.
REQ-026 ABORT: pc==RESET_HANDLER -> IDLE; all other inputs ignored.
REQ-027 SHALL drive exec=1 exactly while state is DONE; reset=1 exactly while state is ABORT; both registered, no combinational path from inputs.
REQ-028 SHALL increment abort_cnt on each transition into ABORT, saturating at 8'hFF.
REQ-029 SHALL retain er_min/er_max across ABORT; ARM is a strobe and is not retained.
REQ-030 When an accepted config write in DONE targets ER address range, SHALL apply both the register update and the IDLE transition in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, er_min=er_max=16'h0000, exec=0, reset=0, abort_cnt=0, independent of clk.
REQ-032 Deassertion of rst_n SHALL take effect at the next rising clk; reset mid-RUN SHALL discard run progress without incrementing abort_cnt.

Verification
REQ-033 Write er_min=16'hE000, er_max=16'hE0FE, ARM; pc E000,E002..E0FE, no irq/dma -> exec=1 one cycle after pc=E0FE, reset=0.
REQ-034 Same config, ARMED, pc jumps to E010 -> reset=1 next cycle, abort_cnt=1; pc=0000 -> IDLE, reset=0 next cycle.
REQ-035 RUN at pc=E020, irq=1 and pc=E0FE same cycle -> ABORT (not DONE), exec stays 0.
REQ-036 DONE, DMA write dma_addr=E050 -> exec=0 next cycle, state IDLE, reset=0, abort_cnt unchanged.
REQ-037 IDLE, er_min=16'hF000, er_max=16'hE000, ARM -> remains IDLE; write during RUN to CFG_BASE -> er_min unchanged.
REQ-038 Force 256 aborts -> abort_cnt=8'hFF, 257th leaves 8'hFF; assert rst_n=0 mid-RUN -> all outputs zero without clock edge.
